// File: rtl/keypad_pkg.sv
// keypad_pkg: shared encodings for the 4x4 keypad scanner.
// Holds FSM states, scan result codes and the hit counting helper.
package keypad_pkg;

   localparam int KEY_W = 4;
   localparam int COL_W = 2;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_PRESSED  = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_SINGLE,
      RES_MULTI
   } scan_res_e;

   // Running hit count for one scan; anything past two is just "many".
   function automatic logic [1:0] hits_sat(
      input logic [1:0] acc,
      input logic [3:0] low
   );
      logic [2:0] s;
      s = {1'b0, acc};
      for (int i = 0; i < 4; i++)
         s = s + {2'b00, low[i]};
      return (s >= 3'd2) ? 2'd2 : s[1:0];
   endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column driver, slot timer and row synchronizer.
// Flags the last slot of each column and the last slot of each scan.
module keypad_col_scan
   import keypad_pkg::*;
#(
   parameter int COL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       row_n,
   output logic [3:0]       col_n,
   output logic [COL_W-1:0] col_idx,
   output logic [3:0]       rows_sync,
   output logic             sample,
   output logic             scan_done
);

   localparam int SLOT_W = $clog2(COL_CYCLES);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(COL_CYCLES - 1);

   logic [3:0]        row_meta;
   logic              active;
   logic [SLOT_W-1:0] slot_cnt;
   logic              slot_last;

   assign slot_last = (slot_cnt == SLOT_LAST);
   assign sample    = active && slot_last;
   assign scan_done = sample && (col_idx == COL_W'(3));
   // Columns stay released until the first cycle after reset.
   assign col_n     = active ? ~(4'b0001 << col_idx) : 4'b1111;

   always_ff @(posedge clk) begin
      if (reset) begin
         row_meta  <= 4'b1111;
         rows_sync <= 4'b1111;
         active    <= 1'b0;
         slot_cnt  <= '0;
         col_idx   <= '0;
      end else begin
         row_meta  <= row_n;
         rows_sync <= row_meta;
         active    <= 1'b1;
         if (active) begin
            if (slot_last) begin
               slot_cnt <= '0;
               col_idx  <= col_idx + COL_W'(1);
            end else begin
               slot_cnt <= slot_cnt + SLOT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan with whole-scan debounce.
// KEYPAD_REPEAT_EN adds auto-repeat pulses while a key is held.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int COL_CYCLES     = 16,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 64
) (
   input  logic             fpga_clk,
   input  logic             reset,
   input  logic [3:0]       row_n,
   output logic [3:0]       col_n,
   output logic             key_valid,
   output logic [KEY_W-1:0] key_code,
   output logic             key_down
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

   logic             sample;
   logic             scan_done;
   logic [COL_W-1:0] col_idx;
   logic [3:0]       rows_sync;

   logic [1:0]       hit_cnt;
   logic [1:0]       hit_nxt;
   logic [KEY_W-1:0] hit_code;
   logic [KEY_W-1:0] code_nxt;
   scan_res_e        res;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [KEY_W-1:0] cand;
   logic             rpt_fire;

   keypad_col_scan #(
      .COL_CYCLES(COL_CYCLES)
   ) u_col_scan (
      .clk       (fpga_clk),
      .reset     (reset),
      .row_n     (row_n),
      .col_n     (col_n),
      .col_idx   (col_idx),
      .rows_sync (rows_sync),
      .sample    (sample),
      .scan_done (scan_done)
   );

   assign cnt_inc = cnt + CNT_W'(1);

   // Fold the current column into the running scan tally.
   always_comb begin
      hit_nxt  = hits_sat(hit_cnt, ~rows_sync);
      code_nxt = hit_code;
      for (int r = 0; r < 4; r++)
         if (!rows_sync[r])
            code_nxt = {2'(r), col_idx};
      unique case (1'b1)
         hit_nxt == 2'd0: res = RES_NONE;
         hit_nxt == 2'd1: res = RES_SINGLE;
         default:         res = RES_MULTI;
      endcase
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_SCANS + 1);
   localparam logic [RPT_W-1:0] RPT_DONE = RPT_W'(REPEAT_SCANS);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_hit;

   assign rpt_hit  = scan_done && (state == ST_PRESSED) &&
                     (res == RES_SINGLE) && (code_nxt == key_code);
   assign rpt_fire = rpt_hit && (rpt_cnt + RPT_W'(1) == RPT_DONE);

   // Any scan outside a matching hold leaves the counter at zero.
   always_ff @(posedge fpga_clk) begin
      if (reset)
         rpt_cnt <= '0;
      else if (scan_done)
         rpt_cnt <= (rpt_hit && !rpt_fire) ? rpt_cnt + RPT_W'(1) : '0;
   end
`else
   logic rpt_unused;
   assign rpt_unused = (REPEAT_SCANS > 0);
   assign rpt_fire   = 1'b0;
`endif

   always_ff @(posedge fpga_clk) begin
      if (reset) begin
         hit_cnt   <= '0;
         hit_code  <= '0;
         state     <= ST_IDLE;
         cnt       <= '0;
         cand      <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_down  <= 1'b0;
      end else begin
         key_valid <= rpt_fire;
         if (sample) begin
            hit_cnt  <= scan_done ? 2'd0 : hit_nxt;
            hit_code <= code_nxt;
         end
         if (scan_done) begin
            unique case (state)
               ST_IDLE: begin
                  if (res == RES_SINGLE) begin
                     state <= ST_DEBOUNCE;
                     cand  <= code_nxt;
                     cnt   <= CNT_W'(1);
                  end
               end
               ST_DEBOUNCE: begin
                  if (res == RES_SINGLE && code_nxt == cand) begin
                     if (cnt_inc == CNT_DONE) begin
                        state     <= ST_PRESSED;
                        cnt       <= '0;
                        key_code  <= cand;
                        key_down  <= 1'b1;
                        key_valid <= 1'b1;
                     end else begin
                        cnt <= cnt_inc;
                     end
                  end else if (res == RES_SINGLE) begin
                     cand <= code_nxt;
                     cnt  <= CNT_W'(1);
                  end else begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end
               end
               ST_PRESSED: begin
                  if (res == RES_NONE) begin
                     state <= ST_RELEASE;
                     cnt   <= CNT_W'(1);
                  end
               end
               default: begin
                  if (res != RES_NONE) begin
                     state <= ST_PRESSED;
                     cnt   <= '0;
                  end else if (cnt_inc == CNT_DONE) begin
                     state    <= ST_IDLE;
                     cnt      <= '0;
                     key_down <= 1'b0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan timing, debounce and key codes.
// Expected pulse count for the long hold follows KEYPAD_REPEAT_EN.
module tb_keypad_scanner;

   localparam int COLS = 8;
   localparam int DEB  = 3;
   localparam int RPT  = 4;
   localparam int SCAN = 4 * COLS;

   logic        fpga_clk = 1'b0;
   logic        reset    = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_down;
   logic [15:0] pressed  = '0;

   int          n_cmp  = 0;
   int          n_bad  = 0;
   int          cyc    = 0;
   int          pulses = 0;
   int          exp_p;
   logic [3:0]  last_code = '0;

   always #5 fpga_clk = ~fpga_clk;

   keypad_scanner #(
      .COL_CYCLES     (COLS),
      .DEBOUNCE_SCANS (DEB),
      .REPEAT_SCANS   (RPT)
   ) dut (
      .fpga_clk  (fpga_clk),
      .reset     (reset),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_down  (key_down)
   );

   // Pressed key {r,c} pulls row r low while column c is driven.
   always_comb begin
      row_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_n[c])
               row_n[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge fpga_clk);
      @(negedge fpga_clk);
      cyc++;
      if (key_valid) begin
         pulses++;
         last_code = key_code;
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic scans(input int n);
      steps(n * SCAN);
   endtask

   task automatic align();
      while (cyc % SCAN != 0) step();
   endtask

   initial begin
      repeat (3) @(posedge fpga_clk);
      @(negedge fpga_clk);
      check("rst_col_n", col_n, 4'b1111);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code", key_code, 4'h0);
      check("rst_down", key_down, 1'b0);

      // scan order
      reset = 1'b0;
      cyc = 0;
      step();
      check("col_c1", col_n, 4'b1110);
      steps(7);
      check("col_c8", col_n, 4'b1110);
      step();
      check("col_c9", col_n, 4'b1101);
      steps(8);
      check("col_c17", col_n, 4'b1011);
      steps(8);
      check("col_c25", col_n, 4'b0111);
      steps(8);
      check("col_c33", col_n, 4'b1110);
      check("idle_pulses", pulses, 0);
      check("idle_down", key_down, 1'b0);
      align();

      // single press row2/col1
      pulses = 0;
      pressed = 16'h1 << 9;
      scans(2);
      check("p2_early", pulses, 0);
      check("p2_down0", key_down, 1'b0);
      scans(1);
      step();
      check("p2_valid", key_valid, 1'b1);
      check("p2_code", key_code, 4'b1001);
      check("p2_down", key_down, 1'b1);
      align();
      scans(1);
      check("p2_once", pulses, 1);

      // release debounce
      pressed = '0;
      scans(2);
      check("r3_hold2", key_down, 1'b1);
      scans(1);
      check("r3_hold3", key_down, 1'b1);
      step();
      check("r3_fall", key_down, 1'b0);
      align();

      // release bounce
      pulses = 0;
      pressed = 16'h1 << 9;
      scans(3);
      step();
      check("b3_press", pulses, 1);
      align();
      pressed = '0;
      scans(1);
      pressed = 16'h1 << 9;
      scans(3);
      check("b3_down", key_down, 1'b1);
      check("b3_nopulse", pulses, 1);
      pressed = '0;
      scans(4);
      check("b3_up", key_down, 1'b0);

      // short glitch
      pulses = 0;
      pressed = 16'h1 << 9;
      scans(2);
      pressed = '0;
      scans(3);
      check("g4_pulses", pulses, 0);
      check("g4_down", key_down, 1'b0);

      // candidate change restarts debounce
      pulses = 0;
      pressed = 16'h1 << 5;
      scans(2);
      pressed = 16'h1 << 10;
      scans(3);
      step();
      check("c_pulses", pulses, 1);
      check("c_code", last_code, 4'b1010);
      align();
      pressed = '0;
      scans(4);

      // two keys, then one
      pulses = 0;
      pressed = (16'h1 << 0) | (16'h1 << 15);
      scans(4);
      check("m5_pulses", pulses, 0);
      check("m5_down", key_down, 1'b0);
      pressed = 16'h1 << 15;
      scans(3);
      step();
      check("m5_valid", key_valid, 1'b1);
      check("m5_code", key_code, 4'b1111);
      align();
      pressed = 16'h1 << 3;
      scans(4);
      check("m5_held_other", pulses, 1);
      check("m5_code_kept", key_code, 4'b1111);
      pressed = '0;
      scans(4);

      // long hold row1/col2
`ifdef KEYPAD_REPEAT_EN
      exp_p = 4;
`else
      exp_p = 1;
`endif
      pulses = 0;
      pressed = 16'h1 << 6;
      scans(15);
      pressed = '0;
      scans(4);
      check("h6_pulses", pulses, exp_p);
      check("h6_code", last_code, 4'b0110);
      check("h6_down", key_down, 1'b0);

      // reset while a key is held
      pressed = 16'h1 << 9;
      scans(3);
      step();
      check("mr_down_pre", key_down, 1'b1);
      reset = 1'b1;
      step();
      check("mr_down", key_down, 1'b0);
      check("mr_code", key_code, 4'h0);
      check("mr_col_n", col_n, 4'b1111);
      check("mr_valid", key_valid, 1'b0);
      step();
      reset = 1'b0;
      cyc = 0;
      pulses = 0;
      step();
      check("mr_valid1", key_valid, 1'b0);
      check("mr_col1", col_n, 4'b1110);
      align();
      scans(2);
      check("mr_nopulse", pulses, 0);
      step();
      check("mr_repress", key_valid, 1'b1);
      check("mr_code9", key_code, 4'b1001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
